// File: rtl/fetch_redirect_if.sv
// fetch_redirect_if
// Bundles the redirect requests coming from ID/branch-resolve and the fetch
// controls going back to the instruction-memory address port.
// The master side is the pipeline (ID, CP0, hazard unit) and the slave side is
// the fetch redirect controller.
interface fetch_redirect_if;
    logic        exc_req;
    logic        eret;
    logic [31:0] cp0_epc;
    logic        stall_hard;
    logic        stall_soft;
    logic [1:0]  br_kind;
    logic        br_slot;
    logic [31:0] br_inst;
    logic [31:0] br_pc;
    logic [31:0] jr_data;
    logic        jr_data_ok;
    logic [31:0] pc;
    logic        flush_if;
    logic        kill_lane2;
    logic        fetch_hold;
    logic [1:0]  state;

    modport master (
        output exc_req, eret, cp0_epc, stall_hard, stall_soft,
               br_kind, br_slot, br_inst, br_pc, jr_data, jr_data_ok,
        input  pc, flush_if, kill_lane2, fetch_hold, state
    );

    modport slave (
        input  exc_req, eret, cp0_epc, stall_hard, stall_soft,
               br_kind, br_slot, br_inst, br_pc, jr_data, jr_data_ok,
        output pc, flush_if, kill_lane2, fetch_hold, state
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
// Program-counter sequencer for the dual-issue fetch stage. Arbitrates
// exception, ERET and branch/jump redirects, parks a redirect across a hard
// stall, waits for forwarded register targets, and generates the wrong-path
// kill signals for the bundle currently in IF.
// Optional feature macro: FETCH_ERET_EN enables the eret/cp0_epc redirect path;
// without it ERET is expected to arrive through exc_req.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'hbfc0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
    parameter logic [31:0] PC_STEP    = 32'd8
) (
    input  logic            clk,
    input  logic            reset,
    fetch_redirect_if.slave bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD_BR = 2'd1,
        WAIT_JR = 2'd2
    } state_e;

    localparam logic [1:0] KindNone = 2'b00;
    localparam logic [1:0] KindBr   = 2'b01;
    localparam logic [1:0] KindJ    = 2'b10;
    localparam logic [1:0] KindJr   = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pendTarget_q, pendTarget_d;
    logic        pendSlot_q, pendSlot_d;
    logic        pendJr_q, pendJr_d;

    logic [31:0] slotPc;
    logic [31:0] brOffset;
    logic [31:0] newTarget;
    logic        newReq;
    logic        newKnown;
    logic        pendReady;
    logic        waitReady;
    logic [31:0] applyTarget;
    logic        applySlot;
    logic        flushIf;
    logic        killLane2;
    logic        fetchHold;
    logic        eretTake;
    logic [31:0] eretPc;
    logic        unusedBits;

`ifdef FETCH_ERET_EN
    assign eretTake   = bus.eret;
    assign eretPc     = bus.cp0_epc;
    assign unusedBits = ^bus.br_inst[31:26];
`else
    assign eretTake   = 1'b0;
    assign eretPc     = 32'd0;
    assign unusedBits = ^{bus.br_inst[31:26], bus.eret, bus.cp0_epc};
`endif

    // A new request is only accepted from RUN; in the other states a pending
    // redirect already owns the single slot and new requests are ignored.
    assign newReq    = (state_q == RUN) && (bus.br_kind != KindNone);
    assign newKnown  = newReq && ((bus.br_kind != KindJr) || bus.jr_data_ok);
    assign pendReady = (state_q == HOLD_BR) && (!pendJr_q || bus.jr_data_ok);
    assign waitReady = (state_q == WAIT_JR) && bus.jr_data_ok;

    // Resolve the target of the control instruction currently presented by ID.
    always_comb begin
        slotPc   = bus.br_pc + 32'd4;
        brOffset = {{14{bus.br_inst[15]}}, bus.br_inst[15:0], 2'b00};
        case (bus.br_kind)
            KindBr:  newTarget = slotPc + brOffset;
            KindJ:   newTarget = {slotPc[31:28], bus.br_inst[25:0], 2'b00};
            default: newTarget = bus.jr_data;
        endcase
    end

    // Pick the redirect being applied this cycle: a fresh request wins over the
    // parked one, and a parked JR takes its target from the forwarding path.
    always_comb begin
        if (newKnown) begin
            applyTarget = newTarget;
            applySlot   = bus.br_slot;
        end else if (pendReady) begin
            applyTarget = pendJr_q ? bus.jr_data : pendTarget_q;
            applySlot   = pendSlot_q;
        end else begin
            applyTarget = bus.jr_data;
            applySlot   = pendSlot_q;
        end
    end

    // Priority arbitration of the next pc, the next FSM state and the kills.
    always_comb begin
        pc_d         = pc_q + PC_STEP;
        state_d      = state_q;
        pendTarget_d = pendTarget_q;
        pendSlot_d   = pendSlot_q;
        pendJr_d     = pendJr_q;
        flushIf      = 1'b0;
        killLane2    = 1'b0;
        fetchHold    = 1'b0;

        if (bus.exc_req) begin
            pc_d         = EXC_VECTOR;
            flushIf      = 1'b1;
            state_d      = RUN;
            pendTarget_d = 32'd0;
            pendSlot_d   = 1'b0;
            pendJr_d     = 1'b0;
        end else if (eretTake) begin
            pc_d         = eretPc;
            flushIf      = 1'b1;
            state_d      = RUN;
            pendTarget_d = 32'd0;
            pendSlot_d   = 1'b0;
            pendJr_d     = 1'b0;
        end else if (bus.stall_hard) begin
            pc_d      = pc_q;
            fetchHold = 1'b1;
            case (state_q)
                RUN: begin
                    if (newReq) begin
                        pendTarget_d = newTarget;
                        pendSlot_d   = bus.br_slot;
                        pendJr_d     = !newKnown;
                        state_d      = HOLD_BR;
                    end
                end
                HOLD_BR: begin
                    if (pendJr_q && bus.jr_data_ok) begin
                        pendTarget_d = bus.jr_data;
                        pendJr_d     = 1'b0;
                    end
                end
                WAIT_JR: begin
                    if (bus.jr_data_ok) begin
                        pendTarget_d = bus.jr_data;
                        pendJr_d     = 1'b0;
                        state_d      = HOLD_BR;
                    end
                end
                default: state_d = RUN;
            endcase
        end else if (newKnown || pendReady || waitReady) begin
            pc_d         = applyTarget;
            state_d      = RUN;
            flushIf      = !applySlot;
            killLane2    = applySlot;
            pendTarget_d = 32'd0;
            pendSlot_d   = 1'b0;
            pendJr_d     = 1'b0;
        end else if (newReq || (state_q == HOLD_BR)) begin
            pc_d      = pc_q;
            fetchHold = 1'b1;
            state_d   = WAIT_JR;
            if (newReq) begin
                pendSlot_d = bus.br_slot;
                pendJr_d   = 1'b1;
            end
        end else if (state_q == WAIT_JR) begin
            pc_d      = pc_q;
            fetchHold = 1'b1;
        end else if (bus.stall_soft) begin
            pc_d      = pc_q;
            fetchHold = 1'b1;
            state_d   = RUN;
        end else begin
            state_d = RUN;
        end
    end

    // Register pc, FSM state and the single pending redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            state_q      <= RUN;
            pendTarget_q <= 32'd0;
            pendSlot_q   <= 1'b0;
            pendJr_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            pendTarget_q <= pendTarget_d;
            pendSlot_q   <= pendSlot_d;
            pendJr_q     <= pendJr_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.state      = state_q;
    assign bus.flush_if   = flushIf;
    assign bus.kill_lane2 = killLane2;
    assign bus.fetch_hold = fetchHold;

    noRedirectWhilePending: assert property (
        @(posedge clk) disable iff (!reset)
        (state_q == RUN) || (bus.br_kind == KindNone)
    );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl
// Scenario-driven bench for fetch_redirect_ctrl. Each scenario fills a table of
// per-cycle stimulus rows with the expected combinational kills and the
// expected pc/state after the clock edge; the post-edge expectations travel
// through a scoreboard queue and are compared in the following cycle.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] ResetPc   = 32'hbfc0_0000;
    localparam logic [31:0] ExcVector = 32'hbfc0_0380;
    localparam logic [31:0] EpcValue  = 32'h1234_5670;

    localparam logic [1:0] MStep = 2'd0;
    localparam logic [1:0] MHold = 2'd1;
    localparam logic [1:0] MAbs  = 2'd2;

    typedef struct {
        logic        exc;
        logic        eret;
        logic        sh;
        logic        ss;
        logic [1:0]  kind;
        logic        slot;
        logic [31:0] inst;
        logic [31:0] bpc;
        logic [31:0] jrd;
        logic        jrok;
        logic        expFlush;
        logic        expKill;
        logic        expHold;
        logic [1:0]  mode;
        logic [31:0] nextPc;
        logic [1:0]  nextState;
    } row_t;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  state;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    row_t        rows[$];
    exp_t        sb[$];
    logic [31:0] modelPc = ResetPc;
    int          checks = 0;
    int          passes = 0;

    fetch_redirect_if bus();

    fetch_redirect_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Hard upper bound on simulation time so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of pipeline requests onto the interface.
    task automatic applyStimulus(input row_t r);
        bus.exc_req    = r.exc;
        bus.eret       = r.eret;
        bus.cp0_epc    = EpcValue;
        bus.stall_hard = r.sh;
        bus.stall_soft = r.ss;
        bus.br_kind    = r.kind;
        bus.br_slot    = r.slot;
        bus.br_inst    = r.inst;
        bus.br_pc      = r.bpc;
        bus.jr_data    = r.jrd;
        bus.jr_data_ok = r.jrok;
    endtask

    // Append one stimulus row with its expectations to the scenario table.
    task automatic addRow(input logic exc, input logic eret, input logic sh, input logic ss,
                          input logic [1:0] kind, input logic slot, input logic [31:0] inst,
                          input logic [31:0] bpc, input logic [31:0] jrd, input logic jrok,
                          input logic eFlush, input logic eKill, input logic eHold,
                          input logic [1:0] mode, input logic [31:0] nPc, input logic [1:0] nState);
        row_t r;
        r.exc = exc; r.eret = eret; r.sh = sh; r.ss = ss; r.kind = kind; r.slot = slot;
        r.inst = inst; r.bpc = bpc; r.jrd = jrd; r.jrok = jrok;
        r.expFlush = eFlush; r.expKill = eKill; r.expHold = eHold;
        r.mode = mode; r.nextPc = nPc; r.nextState = nState;
        rows.push_back(r);
    endtask

    // Reset values while reset is held and right after it is released.
    task automatic test_reset();
        row_t idle;
        idle = '{default: '0};
        applyStimulus(idle);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.pc !== ResetPc) $display("[TB] FAIL reset pc: got %h, want %h", bus.pc, ResetPc);
        else passes++;
        checks++;
        if (bus.state !== 2'd0) $display("[TB] FAIL reset state: got %0d, want 0", bus.state);
        else passes++;
        checks++;
        if ({bus.flush_if, bus.kill_lane2, bus.fetch_hold} !== 3'b000)
            $display("[TB] FAIL reset kills: got %b, want 000", {bus.flush_if, bus.kill_lane2, bus.fetch_hold});
        else passes++;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.pc !== ResetPc) $display("[TB] FAIL reset release pc: got %h, want %h", bus.pc, ResetPc);
        else passes++;
    endtask

    // Plain sequential fetch, plus a soft stall that freezes pc.
    task automatic test_sequential();
        string name = "sequential";
        rows.delete();
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        addRow(0,0,0,1, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,1, MHold, 32'h0, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        foreach (rows[i]) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.pc !== e.pc) $display("[TB] FAIL %s pc: got %h, want %h", e.tag, bus.pc, e.pc);
                else passes++;
                checks++;
                if (bus.state !== e.state) $display("[TB] FAIL %s state: got %0d, want %0d", e.tag, bus.state, e.state);
                else passes++;
            end
            applyStimulus(rows[i]);
            #1;
            checks++;
            if (bus.flush_if !== rows[i].expFlush) $display("[TB] FAIL %s[%0d] flush_if: got %b, want %b", name, i, bus.flush_if, rows[i].expFlush);
            else passes++;
            checks++;
            if (bus.kill_lane2 !== rows[i].expKill) $display("[TB] FAIL %s[%0d] kill_lane2: got %b, want %b", name, i, bus.kill_lane2, rows[i].expKill);
            else passes++;
            checks++;
            if (bus.fetch_hold !== rows[i].expHold) $display("[TB] FAIL %s[%0d] fetch_hold: got %b, want %b", name, i, bus.fetch_hold, rows[i].expHold);
            else passes++;
            modelPc = (rows[i].mode == MStep) ? modelPc + 32'd8 : (rows[i].mode == MHold) ? modelPc : rows[i].nextPc;
            sb.push_back('{pc: modelPc, state: rows[i].nextState, tag: $sformatf("%s[%0d]", name, i)});
        end
    endtask

    // Conditional branch with slot 0 and J with slot 1.
    task automatic test_redirect();
        string name = "redirect";
        rows.delete();
        addRow(0,0,0,0, 2'b01,0, 32'h0000_0004, 32'hbfc0_0000, 32'h0,0, 1,0,0, MAbs, 32'hbfc0_0014, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        addRow(0,0,0,0, 2'b10,1, 32'h0000_0100, 32'hbfc0_0004, 32'h0,0, 0,1,0, MAbs, 32'hb000_0400, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        foreach (rows[i]) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.pc !== e.pc) $display("[TB] FAIL %s pc: got %h, want %h", e.tag, bus.pc, e.pc);
                else passes++;
                checks++;
                if (bus.state !== e.state) $display("[TB] FAIL %s state: got %0d, want %0d", e.tag, bus.state, e.state);
                else passes++;
            end
            applyStimulus(rows[i]);
            #1;
            checks++;
            if (bus.flush_if !== rows[i].expFlush) $display("[TB] FAIL %s[%0d] flush_if: got %b, want %b", name, i, bus.flush_if, rows[i].expFlush);
            else passes++;
            checks++;
            if (bus.kill_lane2 !== rows[i].expKill) $display("[TB] FAIL %s[%0d] kill_lane2: got %b, want %b", name, i, bus.kill_lane2, rows[i].expKill);
            else passes++;
            checks++;
            if (bus.fetch_hold !== rows[i].expHold) $display("[TB] FAIL %s[%0d] fetch_hold: got %b, want %b", name, i, bus.fetch_hold, rows[i].expHold);
            else passes++;
            modelPc = (rows[i].mode == MStep) ? modelPc + 32'd8 : (rows[i].mode == MHold) ? modelPc : rows[i].nextPc;
            sb.push_back('{pc: modelPc, state: rows[i].nextState, tag: $sformatf("%s[%0d]", name, i)});
        end
    endtask

    // JR whose register target arrives three cycles late; the lane-2 kill
    // decided at request time must show up in the resolve cycle.
    task automatic test_jr_wait();
        string name = "jr_wait";
        rows.delete();
        addRow(0,0,0,0, 2'b11,1, 32'h0, 32'h0, 32'h0,0, 0,0,1, MHold, 32'h0, 2'd2);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,1, MHold, 32'h0, 2'd2);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,1, MHold, 32'h0, 2'd2);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h8000_1000,1, 0,1,0, MAbs, 32'h8000_1000, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        foreach (rows[i]) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.pc !== e.pc) $display("[TB] FAIL %s pc: got %h, want %h", e.tag, bus.pc, e.pc);
                else passes++;
                checks++;
                if (bus.state !== e.state) $display("[TB] FAIL %s state: got %0d, want %0d", e.tag, bus.state, e.state);
                else passes++;
            end
            applyStimulus(rows[i]);
            #1;
            checks++;
            if (bus.flush_if !== rows[i].expFlush) $display("[TB] FAIL %s[%0d] flush_if: got %b, want %b", name, i, bus.flush_if, rows[i].expFlush);
            else passes++;
            checks++;
            if (bus.kill_lane2 !== rows[i].expKill) $display("[TB] FAIL %s[%0d] kill_lane2: got %b, want %b", name, i, bus.kill_lane2, rows[i].expKill);
            else passes++;
            checks++;
            if (bus.fetch_hold !== rows[i].expHold) $display("[TB] FAIL %s[%0d] fetch_hold: got %b, want %b", name, i, bus.fetch_hold, rows[i].expHold);
            else passes++;
            modelPc = (rows[i].mode == MStep) ? modelPc + 32'd8 : (rows[i].mode == MHold) ? modelPc : rows[i].nextPc;
            sb.push_back('{pc: modelPc, state: rows[i].nextState, tag: $sformatf("%s[%0d]", name, i)});
        end
    endtask

    // Taken branch arriving during a two-cycle hard stall is parked and
    // applied on the first free cycle.
    task automatic test_stall_branch();
        string name = "stall_branch";
        rows.delete();
        addRow(0,0,1,0, 2'b01,0, 32'h0000_000d, 32'hbfc0_0008, 32'h0,0, 0,0,1, MHold, 32'h0, 2'd1);
        addRow(0,0,1,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,1, MHold, 32'h0, 2'd1);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 1,0,0, MAbs, 32'hbfc0_0040, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        foreach (rows[i]) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.pc !== e.pc) $display("[TB] FAIL %s pc: got %h, want %h", e.tag, bus.pc, e.pc);
                else passes++;
                checks++;
                if (bus.state !== e.state) $display("[TB] FAIL %s state: got %0d, want %0d", e.tag, bus.state, e.state);
                else passes++;
            end
            applyStimulus(rows[i]);
            #1;
            checks++;
            if (bus.flush_if !== rows[i].expFlush) $display("[TB] FAIL %s[%0d] flush_if: got %b, want %b", name, i, bus.flush_if, rows[i].expFlush);
            else passes++;
            checks++;
            if (bus.kill_lane2 !== rows[i].expKill) $display("[TB] FAIL %s[%0d] kill_lane2: got %b, want %b", name, i, bus.kill_lane2, rows[i].expKill);
            else passes++;
            checks++;
            if (bus.fetch_hold !== rows[i].expHold) $display("[TB] FAIL %s[%0d] fetch_hold: got %b, want %b", name, i, bus.fetch_hold, rows[i].expHold);
            else passes++;
            modelPc = (rows[i].mode == MStep) ? modelPc + 32'd8 : (rows[i].mode == MHold) ? modelPc : rows[i].nextPc;
            sb.push_back('{pc: modelPc, state: rows[i].nextState, tag: $sformatf("%s[%0d]", name, i)});
        end
    endtask

    // Exception beating a branch under hard stall, exception discarding a
    // waiting JR, and ERET (only redirects when the ERET path is built in).
    task automatic test_exception();
        string name = "exception";
        rows.delete();
        addRow(1,0,1,0, 2'b01,0, 32'h0000_0004, 32'hbfc0_0000, 32'h0,0, 1,0,0, MAbs, ExcVector, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        addRow(0,0,0,0, 2'b11,1, 32'h0, 32'h0, 32'h0,0, 0,0,1, MHold, 32'h0, 2'd2);
        addRow(1,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h8000_1000,1, 1,0,0, MAbs, ExcVector, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
`ifdef FETCH_ERET_EN
        addRow(0,1,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 1,0,0, MAbs, EpcValue, 2'd0);
`else
        addRow(0,1,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
`endif
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        foreach (rows[i]) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.pc !== e.pc) $display("[TB] FAIL %s pc: got %h, want %h", e.tag, bus.pc, e.pc);
                else passes++;
                checks++;
                if (bus.state !== e.state) $display("[TB] FAIL %s state: got %0d, want %0d", e.tag, bus.state, e.state);
                else passes++;
            end
            applyStimulus(rows[i]);
            #1;
            checks++;
            if (bus.flush_if !== rows[i].expFlush) $display("[TB] FAIL %s[%0d] flush_if: got %b, want %b", name, i, bus.flush_if, rows[i].expFlush);
            else passes++;
            checks++;
            if (bus.kill_lane2 !== rows[i].expKill) $display("[TB] FAIL %s[%0d] kill_lane2: got %b, want %b", name, i, bus.kill_lane2, rows[i].expKill);
            else passes++;
            checks++;
            if (bus.fetch_hold !== rows[i].expHold) $display("[TB] FAIL %s[%0d] fetch_hold: got %b, want %b", name, i, bus.fetch_hold, rows[i].expHold);
            else passes++;
            modelPc = (rows[i].mode == MStep) ? modelPc + 32'd8 : (rows[i].mode == MHold) ? modelPc : rows[i].nextPc;
            sb.push_back('{pc: modelPc, state: rows[i].nextState, tag: $sformatf("%s[%0d]", name, i)});
        end
    endtask

    // Branch target and sequential increment both wrapping past 2^32.
    task automatic test_wrap();
        string name = "wrap";
        rows.delete();
        addRow(0,0,0,0, 2'b01,1, 32'h0000_0001, 32'hffff_fffc, 32'h0,0, 0,1,0, MAbs, 32'h0000_0004, 2'd0);
        addRow(0,0,0,0, 2'b11,0, 32'h0, 32'h0, 32'hffff_fff8,1, 1,0,0, MAbs, 32'hffff_fff8, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        addRow(0,0,0,0, 2'b00,0, 32'h0, 32'h0, 32'h0,0, 0,0,0, MStep, 32'h0, 2'd0);
        foreach (rows[i]) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (bus.pc !== e.pc) $display("[TB] FAIL %s pc: got %h, want %h", e.tag, bus.pc, e.pc);
                else passes++;
                checks++;
                if (bus.state !== e.state) $display("[TB] FAIL %s state: got %0d, want %0d", e.tag, bus.state, e.state);
                else passes++;
            end
            applyStimulus(rows[i]);
            #1;
            checks++;
            if (bus.flush_if !== rows[i].expFlush) $display("[TB] FAIL %s[%0d] flush_if: got %b, want %b", name, i, bus.flush_if, rows[i].expFlush);
            else passes++;
            checks++;
            if (bus.kill_lane2 !== rows[i].expKill) $display("[TB] FAIL %s[%0d] kill_lane2: got %b, want %b", name, i, bus.kill_lane2, rows[i].expKill);
            else passes++;
            checks++;
            if (bus.fetch_hold !== rows[i].expHold) $display("[TB] FAIL %s[%0d] fetch_hold: got %b, want %b", name, i, bus.fetch_hold, rows[i].expHold);
            else passes++;
            modelPc = (rows[i].mode == MStep) ? modelPc + 32'd8 : (rows[i].mode == MHold) ? modelPc : rows[i].nextPc;
            sb.push_back('{pc: modelPc, state: rows[i].nextState, tag: $sformatf("%s[%0d]", name, i)});
        end
    endtask

    // Drain the last scoreboard entry, then assert reset while in WAIT_JR.
    task automatic test_reset_mid();
        row_t r;
        @(negedge clk);
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.pc !== e.pc) $display("[TB] FAIL %s pc: got %h, want %h", e.tag, bus.pc, e.pc);
            else passes++;
            checks++;
            if (bus.state !== e.state) $display("[TB] FAIL %s state: got %0d, want %0d", e.tag, bus.state, e.state);
            else passes++;
        end
        r = '{default: '0};
        r.kind = 2'b11;
        applyStimulus(r);
        @(negedge clk);
        r.kind = 2'b00;
        applyStimulus(r);
        #1;
        checks++;
        if (bus.state !== 2'd2) $display("[TB] FAIL reset_mid enter state: got %0d, want 2", bus.state);
        else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.pc !== ResetPc) $display("[TB] FAIL reset_mid pc: got %h, want %h", bus.pc, ResetPc);
        else passes++;
        checks++;
        if (bus.state !== 2'd0) $display("[TB] FAIL reset_mid state: got %0d, want 0", bus.state);
        else passes++;
        checks++;
        if (bus.fetch_hold !== 1'b0) $display("[TB] FAIL reset_mid fetch_hold: got %b, want 0", bus.fetch_hold);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (bus.pc !== ResetPc) $display("[TB] FAIL reset_mid held pc: got %h, want %h", bus.pc, ResetPc);
        else passes++;
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_jr_wait();
        test_stall_branch();
        test_exception();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
